// File: rtl/in_service_control.sv
// 8259-style in-service register, INTA sequencer and priority rotation.
// Define PIC_AUTO_EOI_EN to let the ISR bit clear itself at the end of the acknowledge.
module in_service_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       interrupt_acknowledge,
    input  logic [4:0] vector_base,
    input  logic       eoi_nonspecific,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    input  logic       set_priority,
    input  logic       auto_eoi_config,
    input  logic       auto_rotate_config,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_interrupt_request,
    output logic       interrupt_to_cpu,
    output logic [7:0] interrupt_vector,
    output logic       vector_valid
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    state_t     state, state_next;
    logic [2:0] level, level_next;
    logic       spurious, spurious_next;
    logic [7:0] isr_next, set_mask, clr_mask;
    logic [2:0] rotate_next, eoi_lvl, scan;
    logic       eoi_rot_en, aeoi_rot, found;
    logic [7:0] clear_next, vector_next;
    logic       int_next, valid_next;

`ifndef PIC_AUTO_EOI_EN
    logic unused_auto_cfg;
    assign unused_auto_cfg = auto_eoi_config ^ auto_rotate_config;
`endif

    function automatic logic [2:0] encode(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

    // Scan from (rotate+1) round to rotate; first set ISR bit is the highest in service.
    always_comb begin
        highest_level_in_service = '0;
        found = 1'b0;
        scan  = '0;
        for (int i = 1; i <= 8; i++) begin
            scan = priority_rotate + 3'(i);
            if (!found && in_service_register[scan]) begin
                highest_level_in_service[scan] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        level_next    = level;
        spurious_next = spurious;
        set_mask      = '0;
        clr_mask      = '0;
        aeoi_rot      = 1'b0;
        eoi_rot_en    = 1'b0;
        eoi_lvl       = '0;
        clear_next    = '0;
        int_next      = interrupt_to_cpu;
        vector_next   = interrupt_vector;
        valid_next    = 1'b0;

        case (state)
            IDLE: begin
                int_next = |interrupt;
                if (interrupt_acknowledge) begin
                    state_next = ACK1;
                    int_next   = 1'b0;
                    if (|interrupt) begin
                        level_next    = encode(interrupt);
                        spurious_next = 1'b0;
                        set_mask      = interrupt;
                        clear_next    = interrupt;
                    end else begin
                        level_next    = 3'd7;
                        spurious_next = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (interrupt_acknowledge) begin
                    vector_next = {vector_base, level};
                    valid_next  = 1'b1;
                    state_next  = ACK2;
                end
            end
            ACK2: begin
                state_next = IDLE;
`ifdef PIC_AUTO_EOI_EN
                if (auto_eoi_config && !spurious) begin
                    clr_mask[level] = 1'b1;
                    aeoi_rot        = auto_rotate_config;
                end
`endif
            end
            default: state_next = IDLE;
        endcase

        // A non-specific EOI with nothing in service leaves everything untouched.
        if (eoi_nonspecific) begin
            if (|highest_level_in_service) begin
                clr_mask   = clr_mask | highest_level_in_service;
                eoi_lvl    = encode(highest_level_in_service);
                eoi_rot_en = rotate_on_eoi;
            end
        end else if (eoi_specific) begin
            clr_mask[eoi_level] = 1'b1;
            eoi_lvl    = eoi_level;
            eoi_rot_en = rotate_on_eoi;
        end

        // Set is ORed in after clearing so a same-bit set survives.
        isr_next = (in_service_register & ~clr_mask) | set_mask;

        if (set_priority)    rotate_next = eoi_level;
        else if (eoi_rot_en) rotate_next = eoi_lvl;
        else if (aeoi_rot)   rotate_next = level;
        else                 rotate_next = priority_rotate;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            level                   <= '0;
            spurious                <= 1'b0;
            in_service_register     <= '0;
            priority_rotate         <= 3'b111;
            clear_interrupt_request <= '0;
            interrupt_to_cpu        <= 1'b0;
            interrupt_vector        <= '0;
            vector_valid            <= 1'b0;
        end else begin
            state                   <= state_next;
            level                   <= level_next;
            spurious                <= spurious_next;
            in_service_register     <= isr_next;
            priority_rotate         <= rotate_next;
            clear_interrupt_request <= clear_next;
            interrupt_to_cpu        <= int_next;
            interrupt_vector        <= vector_next;
            vector_valid            <= valid_next;
        end
    end

endmodule

// File: tb/tb_in_service_control.sv
// Directed and randomized bench for in_service_control against a priority-rule model.
module tb_in_service_control;

    logic       clock;
    logic       reset;
    logic [7:0] interrupt;
    logic       interrupt_acknowledge;
    logic [4:0] vector_base;
    logic       eoi_nonspecific;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       rotate_on_eoi;
    logic       set_priority;
    logic       auto_eoi_config;
    logic       auto_rotate_config;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic [7:0] clear_interrupt_request;
    logic       interrupt_to_cpu;
    logic [7:0] interrupt_vector;
    logic       vector_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_isr;
    int         m_rot;

    in_service_control dut (
        .clock                    (clock),
        .reset                    (reset),
        .interrupt                (interrupt),
        .interrupt_acknowledge    (interrupt_acknowledge),
        .vector_base              (vector_base),
        .eoi_nonspecific          (eoi_nonspecific),
        .eoi_specific             (eoi_specific),
        .eoi_level                (eoi_level),
        .rotate_on_eoi            (rotate_on_eoi),
        .set_priority             (set_priority),
        .auto_eoi_config          (auto_eoi_config),
        .auto_rotate_config       (auto_rotate_config),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .priority_rotate          (priority_rotate),
        .clear_interrupt_request  (clear_interrupt_request),
        .interrupt_to_cpu         (interrupt_to_cpu),
        .interrupt_vector         (interrupt_vector),
        .vector_valid             (vector_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Highest priority is rot+1, walking upward modulo 8.
    function automatic logic [7:0] model_highest(input logic [7:0] isr, input int rot);
        int l;
        for (int k = 1; k <= 8; k++) begin
            l = (rot + k) % 8;
            if (isr[l]) return 8'(1 << l);
        end
        return 8'h00;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_isr"}, in_service_register, m_isr);
        check({tag, "_rot"}, priority_rotate, m_rot);
        check({tag, "_hlis"}, highest_level_in_service, model_highest(m_isr, m_rot));
    endtask

    task automatic do_inta(input logic [7:0] req, input logic aeoi, input logic arot,
                           input logic eoi_at_ack, input logic [2:0] eoi_lvl_at_ack,
                           input logic ack_in_ack2);
        int lvl;
        logic [7:0] exp_vec;
        lvl = 7;
        for (int i = 0; i < 8; i++) if (req[i]) lvl = i;
        exp_vec = 8'(vector_base * 8 + lvl);
        auto_eoi_config    = aeoi;
        auto_rotate_config = arot;
        interrupt = req;
        tick();
        check("int_req", interrupt_to_cpu, req != 0);
        interrupt_acknowledge = 1'b1;
        eoi_specific = eoi_at_ack;
        eoi_level    = eoi_lvl_at_ack;
        tick();
        interrupt_acknowledge = 1'b0;
        eoi_specific = 1'b0;
        interrupt    = 8'h00;
        if (eoi_at_ack) m_isr[eoi_lvl_at_ack] = 1'b0;
        m_isr = m_isr | req;
        check("ack1_clear", clear_interrupt_request, req);
        check("ack1_int", interrupt_to_cpu, 1'b0);
        check_state("ack1");
        tick();
        check("gap_clear", clear_interrupt_request, 8'h00);
        check("gap_valid", vector_valid, 1'b0);
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = ack_in_ack2;
        check("vec", interrupt_vector, exp_vec);
        check("vec_valid", vector_valid, 1'b1);
        tick();
        interrupt_acknowledge = 1'b0;
`ifdef PIC_AUTO_EOI_EN
        if (aeoi && req != 0) begin
            m_isr[lvl] = 1'b0;
            if (arot) m_rot = lvl;
        end
`endif
        check("ack2_valid", vector_valid, 1'b0);
        check("ack2_clear", clear_interrupt_request, 8'h00);
        check_state("ack2");
        tick();
        check("post_valid", vector_valid, 1'b0);
        check("post_int", interrupt_to_cpu, 1'b0);
        auto_eoi_config    = 1'b0;
        auto_rotate_config = 1'b0;
    endtask

    task automatic do_eoi(input logic nonspec, input logic spec, input logic [2:0] lvl,
                          input logic rot_on, input logic setp);
        logic [7:0] h;
        eoi_nonspecific = nonspec;
        eoi_specific    = spec;
        eoi_level       = lvl;
        rotate_on_eoi   = rot_on;
        set_priority    = setp;
        tick();
        eoi_nonspecific = 1'b0;
        eoi_specific    = 1'b0;
        rotate_on_eoi   = 1'b0;
        set_priority    = 1'b0;
        if (nonspec) begin
            h = model_highest(m_isr, m_rot);
            for (int l = 0; l < 8; l++) begin
                if (h[l]) begin
                    m_isr[l] = 1'b0;
                    if (rot_on) m_rot = l;
                end
            end
        end else if (spec) begin
            m_isr[lvl] = 1'b0;
            if (rot_on) m_rot = int'(lvl);
        end
        if (setp) m_rot = int'(lvl);
        check_state("eoi");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_isr"}, in_service_register, 8'h00);
        check({tag, "_rot"}, priority_rotate, 3'b111);
        check({tag, "_vec"}, interrupt_vector, 8'h00);
        check({tag, "_valid"}, vector_valid, 1'b0);
        check({tag, "_clear"}, clear_interrupt_request, 8'h00);
        check({tag, "_int"}, interrupt_to_cpu, 1'b0);
    endtask

    initial begin
        logic [7:0] req;
        int r;
        reset = 1'b1;
        interrupt = '0;
        interrupt_acknowledge = 1'b0;
        vector_base = 5'b01000;
        eoi_nonspecific = 1'b0;
        eoi_specific = 1'b0;
        eoi_level = '0;
        rotate_on_eoi = 1'b0;
        set_priority = 1'b0;
        auto_eoi_config = 1'b0;
        auto_rotate_config = 1'b0;
        m_isr = 8'h00;
        m_rot = 7;
        tick();
        tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // INT follows the request with one cycle of latency both ways.
        interrupt = 8'h04;
        tick();
        check("int_rise", interrupt_to_cpu, 1'b1);
        interrupt = 8'h00;
        tick();
        check("int_fall", interrupt_to_cpu, 1'b0);

        // Single request, vector base 01000 -> 0x42.
        do_inta(8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("single_vec", interrupt_vector, 8'h42);
        check("single_isr", in_service_register, 8'h04);
        do_eoi(1'b0, 1'b1, 3'd2, 1'b0, 1'b0);

        // Spurious acknowledge.
        do_inta(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("spur_isr", in_service_register, 8'h00);
        check("spur_vec", interrupt_vector, 8'h47);

        // Nested service, rotate 7.
        do_inta(8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        do_inta(8'h20, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("nest_isr", in_service_register, 8'h24);
        do_eoi(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        check("nest_ns", in_service_register, 8'h20);
        do_eoi(1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        check("nest_sp", in_service_register, 8'h00);
        do_eoi(1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        check("empty_eoi_rot", priority_rotate, 3'd7);

        // Rotate on EOI.
        do_inta(8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        do_eoi(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        check("rot_val", priority_rotate, 3'd3);
        do_inta(8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        do_inta(8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("rot_hlis", highest_level_in_service, 8'h10);
        do_eoi(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        do_eoi(1'b0, 1'b1, 3'd4, 1'b0, 1'b0);

        // Auto EOI.
        vector_base = 5'b10101;
        do_inta(8'h04, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
`ifdef PIC_AUTO_EOI_EN
        check("aeoi_isr", in_service_register, 8'h00);
`else
        check("aeoi_isr", in_service_register, 8'h04);
`endif
        do_eoi(1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        do_inta(8'h40, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        do_eoi(1'b0, 1'b1, 3'd6, 1'b0, 1'b0);

        // Set and clear in one cycle: same bit keeps set, different bits both apply.
        do_inta(8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        do_inta(8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        check("coll_same", in_service_register, 8'h04);
        do_inta(8'h02, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        check("coll_diff", in_service_register, 8'h02);
        do_eoi(1'b0, 1'b1, 3'd1, 1'b0, 1'b0);

        // set_priority beats rotate-on-EOI; INTA held through ACK2 is ignored.
        do_inta(8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        check("ack2_ign_isr", in_service_register, 8'h01);
        do_eoi(1'b1, 1'b0, 3'd5, 1'b1, 1'b1);
        check("setp_win", priority_rotate, 3'd5);

        // Reset during ACK1 aborts with no vector.
        interrupt = 8'h10;
        tick();
        interrupt_acknowledge = 1'b1;
        tick();
        interrupt_acknowledge = 1'b0;
        interrupt = 8'h00;
        reset = 1'b1;
        #2;
        check_reset_values("midack");
        tick();
        reset = 1'b0;
        m_isr = 8'h00;
        m_rot = 7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midack_novalid", vector_valid, 1'b0);
        end
        check_state("midack");

        // Randomized mix of acknowledges and EOI commands.
        for (int it = 0; it < 60; it++) begin
            vector_base = 5'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                r = int'($urandom_range(0, 8));
                req = (r == 8) ? 8'h00 : 8'(1 << r);
                do_inta(req, 1'($urandom), 1'($urandom), 1'b0, 3'd0, 1'($urandom));
            end else begin
                do_eoi(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
